ifetch_unit: RTL

Instruction fetch stage: owns the PC, reads instruction memory through a req/ack handshake, and hands one instruction at a time to decode and the immediate builder with a valid/ready handshake.
Consumes the resolved control-flow result (taken branch, jal, jalr) together with the sign-extended imm32 from the immediate builder, and redirects the PC.
Multi-cycle. One instruction is in flight at a time.

---
 rtl/ifetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a req/ack
// memory port, hands it to decode with valid/ready, and follows resolved redirects.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        br_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] imm32,
  input  logic [31:0] rs1_data,
  output logic        misalign_fault
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {BOOT, REQ, HOLD, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        discard;

  logic        redirect;
  logic [31:0] target;
  logic        misaligned;

  // Redirect target; jalr wins over the pc-relative forms.
  always_comb begin
    redirect   = br_taken | jal | jalr;
    target     = ex_pc + imm32;
    if (jalr) target = (rs1_data + imm32) & ~32'h1;
    misaligned = |target[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      discard        <= 1'b0;
      imem_req       <= 1'b0;
      imem_addr      <= 32'h0;
      inst_valid     <= 1'b0;
      instruction    <= 32'h0;
      inst_pc        <= 32'h0;
      misalign_fault <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          imem_req  <= 1'b1;
          imem_addr <= pc;
          state     <= REQ;
        end

        // Request outstanding: the address is frozen until ack.
        REQ: begin
          if (redirect) begin
            if (misaligned) begin
              misalign_fault <= 1'b1;
              inst_valid     <= 1'b0;
              discard        <= 1'b0;
              if (imem_ack) imem_req <= 1'b0;
              state          <= FAULT;
            end else begin
              pc <= target;
              if (imem_ack) begin
                imem_addr <= target;
                discard   <= 1'b0;
              end else begin
                discard   <= 1'b1;
              end
            end
          end else if (imem_ack) begin
            if (discard) begin
              discard   <= 1'b0;
              imem_addr <= pc;
            end else begin
              instruction <= imem_rdata;
              inst_pc     <= imem_addr;
              inst_valid  <= 1'b1;
              pc          <= imem_addr + STEP;
              imem_req    <= 1'b0;
              state       <= HOLD;
            end
          end
        end

        // Instruction presented to decode; a redirect drops it.
        HOLD: begin
          if (redirect) begin
            inst_valid <= 1'b0;
            if (misaligned) begin
              misalign_fault <= 1'b1;
              state          <= FAULT;
            end else begin
              pc        <= target;
              imem_addr <= target;
              imem_req  <= 1'b1;
              state     <= REQ;
            end
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            imem_addr  <= pc;
            imem_req   <= 1'b1;
            state      <= REQ;
          end
        end

        // Terminal until reset; only lets an outstanding request complete.
        FAULT: begin
          if (imem_req && imem_ack) imem_req <= 1'b0;
        end

        default: state <= FAULT;
      endcase
    end
  end

endmodule
